// File: rtl/full_adder.sv
// 1-bit full adder leaf cell with combinational and enable-gated registered outputs.
// Optional FULL_ADDER_XCHK_EN adds a registered flag for unknown inputs (simulation aid).
module full_adder (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic en,
   output logic sum,
   output logic carry,
   output logic sum_q,
   output logic carry_q
`ifdef FULL_ADDER_XCHK_EN
   ,
   output logic x_flag
`endif
);

   // Plain operators so X/Z propagate exactly as 4-state semantics dictate.
   assign sum   = a ^ b ^ c;
   assign carry = (a & b) | (b & c) | (a & c);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q   <= 1'b0;
         carry_q <= 1'b0;
      end else if (en) begin
         sum_q   <= sum;
         carry_q <= carry;
      end
   end

`ifdef FULL_ADDER_XCHK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_flag <= 1'b0;
      end else if (en) begin
         x_flag <= (^{a, b, c} === 1'bx);
      end
   end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder: truth table, X propagation (4-state
// simulators only), registered path with enable and asynchronous reset.
module tb_full_adder;

   logic clk = 1'b0;
   logic rst;
   logic a, b, c, en;
   logic sum, carry, sum_q, carry_q;
`ifdef FULL_ADDER_XCHK_EN
   logic x_flag;
`endif

   int checks = 0;
   int passes = 0;
   logic four_state;
   logic probe;

   full_adder dut (
      .clk     (clk),
      .rst     (rst),
      .a       (a),
      .b       (b),
      .c       (c),
      .en      (en),
      .sum     (sum),
      .carry   (carry),
      .sum_q   (sum_q),
      .carry_q (carry_q)
`ifdef FULL_ADDER_XCHK_EN
      ,
      .x_flag  (x_flag)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %b, want %b", tag, obs, exp);
      end else begin
         passes++;
      end
   endtask

   // Hand-computed truth table, indexed by {a,b,c}.
   logic [7:0] exp_sum_tab   = 8'b1001_0110;
   logic [7:0] exp_carry_tab = 8'b1110_1000;

   // X patterns: xxx, xx0, x00, 00x, 0xx, 0x0 and expected carry X,X,0,0,X,0.
   logic [2:0] xpat_a [6];
   logic [2:0] xpat_b [6];
   logic [2:0] xpat_c [6];
   logic       xexp_carry [6];

   initial begin
      xpat_a = '{1'bx, 1'bx, 1'bx, 1'b0, 1'b0, 1'b0};
      xpat_b = '{1'bx, 1'bx, 1'b0, 1'b0, 1'bx, 1'bx};
      xpat_c = '{1'bx, 1'b0, 1'b0, 1'bx, 1'bx, 1'b0};
      xexp_carry = '{1'bx, 1'bx, 1'b0, 1'b0, 1'bx, 1'b0};

      probe = 1'bx;
      four_state = (probe === 1'bx);

      // Reset held with all-ones inputs: registers must read 0 before any edge.
      rst = 1'b1; en = 1'b0; a = 1'b1; b = 1'b1; c = 1'b1;
      #1;
      check("reset_sum_q", sum_q, 1'b0);
      check("reset_carry_q", carry_q, 1'b0);

      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = i[2:0];
         {a, b, c} = v;
         #1;
         check($sformatf("tt_sum_%0d", i), sum, exp_sum_tab[i]);
         check($sformatf("tt_carry_%0d", i), carry, exp_carry_tab[i]);
         #9;
      end

      if (four_state) begin
         for (int i = 0; i < 6; i++) begin
            a = xpat_a[i][0]; b = xpat_b[i][0]; c = xpat_c[i][0];
            #1;
            check($sformatf("x_sum_%0d", i), sum, 1'bx);
            check($sformatf("x_carry_%0d", i), carry, xexp_carry[i]);
            #9;
         end
      end

      // Release reset, first capture of 1+1+1.
      @(negedge clk);
      a = 1'b1; b = 1'b1; c = 1'b1; en = 1'b1; rst = 1'b0;
      @(negedge clk);
      check("first_cap_sum_q", sum_q, 1'b1);
      check("first_cap_carry_q", carry_q, 1'b1);

      // Capture 011, then hold with en=0 while inputs change.
      {a, b, c} = 3'b011;
      @(negedge clk);
      check("cap011_sum_q", sum_q, 1'b0);
      check("cap011_carry_q", carry_q, 1'b1);
      en = 1'b0;
      {a, b, c} = 3'b100;
      repeat (3) @(negedge clk);
      check("hold_sum_q", sum_q, 1'b0);
      check("hold_carry_q", carry_q, 1'b1);
      check("hold_comb_sum", sum, 1'b1);
      check("hold_comb_carry", carry, 1'b0);

      // Capture 100 -> sum_q=1, then assert reset between edges.
      en = 1'b1;
      @(negedge clk);
      check("cap100_sum_q", sum_q, 1'b1);
      check("cap100_carry_q", carry_q, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_sum_q", sum_q, 1'b0);
      check("async_rst_carry_q", carry_q, 1'b0);
      @(negedge clk);
      check("rst_held_sum_q", sum_q, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_cap_sum_q", sum_q, 1'b1);

`ifdef FULL_ADDER_XCHK_EN
      if (four_state) begin
         {a, b, c} = 3'b000;
         b = 1'bx;
         @(negedge clk);
         check("xflag_set", x_flag, 1'b1);
      end
      {a, b, c} = 3'b000;
      @(negedge clk);
      check("xflag_clear", x_flag, 1'b0);
      rst = 1'b1;
      #1;
      check("xflag_rst", x_flag, 1'b0);
      rst = 1'b0;
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
